// File: rtl/multimode_counter_if.sv
// Control and status bundle for multimode_counter: the controller drives
// the strobes and configuration, the counter returns count, tc and done.
interface multimode_counter_if #(
  parameter int WIDTH = 9,
  parameter int PRE_W = 4
);
  logic             en;
  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             dir;
  logic [1:0]       mode;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;

  modport master (
    output en, load_en, load_data, dir, mode, prescale,
    input  count, tc, done
  );

  modport slave (
    input  en, load_en, load_data, dir, mode, prescale,
    output count, tc, done
  );
endinterface

// File: rtl/multimode_counter.sv
// Loadable up/down timer with prescaler and wrap/saturate/auto-reload/
// one-shot terminal-count handling; all outputs come straight from flops.
module multimode_counter #(
  parameter int WIDTH = 9,
  parameter int PRE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  multimode_counter_if.slave bus
);

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SATURATE = 2'b01;
  localparam logic [1:0] MODE_RELOAD   = 2'b10;
  localparam logic [1:0] MODE_ONESHOT  = 2'b11;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [PRE_W-1:0] p_q;
  logic             tc_q;
  logic             done_q;

  logic             advance;
  logic             tick;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] stepped;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    advance = bus.en && !bus.load_en && !done_q;
    tick    = advance && (p_q == bus.prescale);
    term    = {WIDTH{bus.dir}};
    stepped = bus.dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      reload_q <= '0;
      p_q      <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.load_en) begin
      count_q  <= bus.load_data;
      reload_q <= bus.load_data;
      p_q      <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (advance) begin
        p_q <= tick ? '0 : p_q + PRE_W'(1);
      end
      if (tick) begin
        if (count_q != term) begin
          count_q <= stepped;
        end else begin
          tc_q <= 1'b1;
          unique case (bus.mode)
            MODE_WRAP:     count_q <= stepped;
            MODE_SATURATE: done_q  <= 1'b1;
            MODE_RELOAD:   count_q <= reload_q;
            MODE_ONESHOT: begin
              count_q <= reload_q;
              done_q  <= 1'b1;
            end
            default:       count_q <= count_q;
          endcase
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Directed bench for multimode_counter: each step drives inputs, advances
// clock edges and compares count/tc/done against hand-computed values.
module tb_multimode_counter;

  localparam int WIDTH = 9;
  localparam int PRE_W = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  multimode_counter_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  multimode_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input int c, input bit t, input bit d);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".tc"}, 32'(bus.tc), 32'(t));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
  endtask

  task automatic load(input int value, input bit d, input logic [1:0] m, input int pre);
    bus.load_en   = 1'b1;
    bus.load_data = WIDTH'(value);
    bus.dir       = d;
    bus.mode      = m;
    bus.prescale  = PRE_W'(pre);
    cycles(1);
    bus.load_en   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_data = '0;
    bus.dir       = 1'b0;
    bus.mode      = 2'b00;
    bus.prescale  = '0;
    #12;
    expect3("reset_state", 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycles(1);

    // Saturate to get done=1, then reset mid-run between clock edges.
    load(510, 1'b1, 2'b01, 0);
    bus.en = 1'b1;
    cycles(2);
    expect3("pre_reset_sat", 511, 1'b1, 1'b1);
    rst_n = 1'b0;
    #2;
    expect3("async_reset", 0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    cycles(1);
    load(9'h1A5, 1'b0, 2'b00, 0);
    bus.en = 1'b0;
    expect3("load_1a5", 9'h1A5, 1'b0, 1'b0);

    // Down wrap, prescale=1: one step every two cycles.
    load(3, 1'b0, 2'b00, 1);
    bus.en = 1'b1;
    cycles(1);
    check("wrap_prescale_hold", 32'(bus.count), 3);
    cycles(1);
    check("wrap_2", 32'(bus.count), 2);
    cycles(2);
    check("wrap_1", 32'(bus.count), 1);
    cycles(2);
    expect3("wrap_0", 0, 1'b0, 1'b0);
    cycles(1);
    check("wrap_0_hold", 32'(bus.count), 0);
    cycles(1);
    expect3("wrap_511", 511, 1'b1, 1'b0);
    cycles(1);
    expect3("wrap_tc_clear", 511, 1'b0, 1'b0);

    // Up saturate.
    load(509, 1'b1, 2'b01, 0);
    cycles(1);
    check("sat_510", 32'(bus.count), 510);
    cycles(1);
    expect3("sat_511", 511, 1'b0, 1'b0);
    cycles(1);
    expect3("sat_term", 511, 1'b1, 1'b1);
    cycles(3);
    expect3("sat_hold", 511, 1'b0, 1'b1);
    bus.mode = 2'b00;
    cycles(2);
    expect3("sat_mode_change_keeps_done", 511, 1'b0, 1'b1);
    load(5, 1'b1, 2'b01, 0);
    expect3("sat_reload_5", 5, 1'b0, 1'b0);

    // Auto-reload period of five ticks, then freeze with en low.
    load(4, 1'b0, 2'b10, 0);
    cycles(1);
    check("ar_3", 32'(bus.count), 3);
    cycles(3);
    expect3("ar_0", 0, 1'b0, 1'b0);
    cycles(1);
    expect3("ar_reload", 4, 1'b1, 1'b0);
    cycles(1);
    expect3("ar_3b", 3, 1'b0, 1'b0);
    bus.en = 1'b0;
    cycles(3);
    expect3("ar_frozen", 3, 1'b0, 1'b0);
    bus.en = 1'b1;
    cycles(1);
    check("ar_resume", 32'(bus.count), 2);

    // Auto-reload with reload equal to the terminal value.
    load(0, 1'b0, 2'b10, 0);
    cycles(1);
    expect3("ar_t_1", 0, 1'b1, 1'b0);
    cycles(1);
    expect3("ar_t_2", 0, 1'b1, 1'b0);

    // One-shot.
    load(2, 1'b0, 2'b11, 0);
    cycles(2);
    expect3("os_0", 0, 1'b0, 1'b0);
    cycles(1);
    expect3("os_fire", 2, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      expect3("os_idle", 2, 1'b0, 1'b1);
    end

    // Load on the exact terminal tick (saturate would otherwise set done).
    load(1, 1'b0, 2'b01, 0);
    cycles(1);
    check("sim_at_t", 32'(bus.count), 0);
    bus.load_en   = 1'b1;
    bus.load_data = 9'h055;
    cycles(1);
    bus.load_en   = 1'b0;
    expect3("sim_load_wins", 9'h055, 1'b0, 1'b0);

    // Direction flip mid-count.
    load(9, 1'b0, 2'b00, 0);
    cycles(2);
    check("dir_7", 32'(bus.count), 7);
    bus.dir = 1'b1;
    cycles(1);
    check("dir_flip_8", 32'(bus.count), 8);

    // Reset mid-count, then resume from 0 counting up once en allows it.
    rst_n = 1'b0;
    #2;
    expect3("rst_mid", 0, 1'b0, 1'b0);
    bus.en = 1'b0;
    #1;
    rst_n = 1'b1;
    cycles(2);
    check("rst_en_low_hold", 32'(bus.count), 0);
    bus.en = 1'b1;
    cycles(1);
    check("rst_resume_up", 32'(bus.count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multimode_counter.md
Name: multimode_counter

Overview:
Parametrised timer/counter, successor to the fixed 9-bit loadable down-counter. Adds:
- selectable count direction
- a prescaler
- four terminal-count modes: wrap, saturate, auto-reload, one-shot
- a registered terminal-count pulse and a done flag

Sits behind the top-level pin wrapper: controls from dedicated inputs, count value to outputs.

Parameters:
WIDTH, 9, counter and load-data width in bits (>=2).
PRE_W, 4, prescaler compare width in bits (>=1).

Ports:
clk  input  1  single clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  count enable; low freezes prescaler and count.
load_en  input  1  synchronous load strobe.
load_data  input  WIDTH  value written to count and reload register.
dir  input  1  1 = count up, 0 = count down.
mode  input  2  00 wrap, 01 saturate, 10 auto-reload, 11 one-shot.
prescale  input  PRE_W  tick every prescale+1 enabled cycles.
count  output  WIDTH  current count, registered.
tc  output  1  one-cycle terminal-count pulse, registered.
done  output  1  sticky stop flag, registered.

Behaviour:
- Reset (rst_n=0, async) clears all state to 0: count, reload register, prescaler counter p, tc, done. No clock needed.
- Load has priority over everything.
  - load_en=1 at an edge: count<=load_data, reload<=load_data, p<=0, done<=0, tc<=0.
  - en is ignored on a load cycle.
- Prescaler:
  - When en=1, no load, done=0: if p==prescale then tick=1 and p<=0, else p<=p+1.
  - prescale=0 gives a tick every enabled cycle.
  - prescale changes apply from the next compare.
  - en=0 holds p and count.
- Terminal value T: 0 when dir=0, 2^WIDTH-1 when dir=1.
  - dir and mode are sampled at each tick; a mid-count change applies at the next tick.
- Tick with count!=T: count<=count-1 (dir=0) or count+1 (dir=1), modulo 2^WIDTH. tc<=0.
- Tick with count==T: tc<=1 for exactly the next cycle. Then, by mode:
  - 00 wrap: count<=count∓1 with natural wrap (0->max down, max->0 up). done unchanged.
  - 01 saturate: count holds T; done<=1.
  - 10 auto-reload: count<=reload; continues counting.
  - 11 one-shot: count<=reload; done<=1.
- While done=1, ticks are suppressed: p and count hold, tc stays 0.
  - done clears only on load or reset. Changing mode does not clear it.
- Non-tick cycles: tc<=0.
- Latency: count and tc update on the edge where the tick is sampled. Observable one cycle after the qualifying edge; no combinational input-to-output path.
- Reload equal to T in auto-reload (e.g. reload=0, dir=0): tc pulses on every tick, count stays T.
- Reset asserted mid-count aborts immediately. After release, count resumes from 0 (with reload 0) only when en=1.

Test Plan:
- Reset/load: rst_n low mid-count -> count=0, tc=0, done=0 asynchronously. Then load_data=9'h1A5, load_en pulse -> count=0x1A5 next cycle.
- Down wrap with prescaler: load 3, dir=0, mode=00, prescale=1, en=1 -> count steps 3,2,1,0 every 2 cycles. Next tick -> count=511, with tc=1 for one cycle coincident with 511.
- Up saturate: load 509, dir=1, mode=01, prescale=0 -> 510, 511. Next tick -> stays 511, tc pulse, done=1. Further ticks: count 511, tc 0. Load 5 -> done=0, count=5.
- Auto-reload period: load 4, dir=0, mode=10, prescale=0 -> 4,3,2,1,0,4,3,... with tc every 5th cycle. en low for 3 cycles -> count frozen, no tc.
- One-shot: load 2, dir=0, mode=11 -> 2,1,0, then count=2 with tc pulse, done=1, no further change for 20 cycles.
- Simultaneous events: load_en=1 on the exact tick where count==T -> count=load_data, tc=0, done=0. dir flipped mid-count at count=7 (was down) -> next tick gives 8.
